register_file: RTL
==================

Name: register_file

Overview:
- 32-entry general-purpose register file of the MIPS datapath.
- Sits directly downstream of the writeback 8:1 select mux. The mux output drives wr_data; register reads feed the decode stage and ALU operand muxes.
- Two combinational read ports with write-through bypass, one synchronous write port, and one debug read port.
- Register 0 is hardwired to zero.

Parameters:
- bus_size, 32, width of each register and of every data port.
- addr_size, 5, register address width; depth = 2**addr_size.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears every register.
- wr_en  input  1  write enable for the write port.
- rd_addr  input  addr_size  destination register address.
- wr_data  input  bus_size  write data (output of the writeback mux).
- rs_addr  input  addr_size  read port A address.
- rt_addr  input  addr_size  read port B address.
- dbg_addr  input  addr_size  debug read port address.
- rs_data  output  bus_size  read port A data.
- rt_data  output  bus_size  read port B data.
- dbg_data  output  bus_size  debug read data, stored contents only, no bypass.
- wr_count  output  16  number of committed writes since reset.

Behaviour:
- Storage: 2**addr_size registers, bus_size bits each. Entry 0 is not stored (constant zero).
- Reset:
  - rst high clears all entries to 0 and wr_count to 0, immediately and independent of clk.
  - While rst is high, writes are ignored and all read outputs read 0.
  - On rst deassertion, the first write may occur at the next rising edge.
- Write:
  - At the rising edge of clk with rst low, wr_en high and rd_addr != 0: entry[rd_addr] <= wr_data and wr_count increments by 1.
  - wr_en high with rd_addr == 0: no state change and wr_count does not increment.
  - wr_count wraps from 16'hFFFF to 0.
- Read (ports A and B, combinational, zero latency):
  - If addr == 0: data = 0.
  - Else if wr_en high and rd_addr == addr: data = wr_data (write-through bypass). This makes a same-cycle writeback visible to decode with no extra hazard cycle.
  - Else: data = entry[addr].
  - A and B are independent. Both may hit the same register and both may be bypassed in the same cycle.
- Debug read: dbg_data = entry[dbg_addr] (0 for address 0), combinational, never bypassed.
  - A write becomes visible on dbg_data only after the clock edge that commits it.
- No read-side state: outputs change only with address, wr_en/rd_addr/wr_data (bypass), committed writes, or rst.
- Width rules: wr_data is stored at full bus_size width with no extension or truncation.
- X-handling: wr_en low makes rd_addr and wr_data don't-care. No state change may occur.

Test Plan:
- Reset: load r1..r31 with nonzero values, pulse rst asynchronously between clock edges -> all rs_data/rt_data/dbg_data reads return 0 immediately, wr_count = 0.
- Basic write/read: write 32'hDEADBEEF to r5, next cycle rs_addr=5, rt_addr=5 -> both outputs 32'hDEADBEEF, dbg_addr=5 -> 32'hDEADBEEF, wr_count = 1.
- r0 immutability: wr_en=1, rd_addr=0, wr_data=32'hFFFFFFFF -> rs_addr=0 reads 0 in the same and next cycle, wr_count unchanged.
- Bypass: r7 holds 32'h11111111; in one cycle set wr_en=1, rd_addr=7, wr_data=32'h22222222, rs_addr=7, rt_addr=3:
  - before the edge: rs_data=32'h22222222, dbg_data(7)=32'h11111111, rt_data = r3 contents.
  - after the edge: dbg_data=32'h22222222.
- Back-to-back writes: write r10=1, r10=2, r11=3 on consecutive cycles -> final r10=2, r11=3, wr_count=3. Reads of r10 during the second write cycle return 2 via bypass.
- Reset mid-operation: assert rst in the same cycle as wr_en=1, rd_addr=9, wr_data=32'hA5A5A5A5 -> r9 reads 0 after rst release, wr_count=0.

Source files
------------

// File: rtl/register_file_if.sv
// Register file port bundle: one write port, two bypassed read ports,
// one debug read port and the committed-write counter.
interface register_file_if #(
  parameter int bus_size  = 32,
  parameter int addr_size = 5
);
  logic                 wr_en;
  logic [addr_size-1:0] rd_addr;
  logic [bus_size-1:0]  wr_data;
  logic [addr_size-1:0] rs_addr;
  logic [addr_size-1:0] rt_addr;
  logic [addr_size-1:0] dbg_addr;
  logic [bus_size-1:0]  rs_data;
  logic [bus_size-1:0]  rt_data;
  logic [bus_size-1:0]  dbg_data;
  logic [15:0]          wr_count;

  modport master (
    output wr_en, rd_addr, wr_data, rs_addr, rt_addr, dbg_addr,
    input  rs_data, rt_data, dbg_data, wr_count
  );

  modport slave (
    input  wr_en, rd_addr, wr_data, rs_addr, rt_addr, dbg_addr,
    output rs_data, rt_data, dbg_data, wr_count
  );
endinterface

// File: rtl/register_file.sv
// MIPS general-purpose register file: r0 hardwired to zero, two combinational
// read ports with write-through bypass, one synchronous write port, debug read.
module register_file #(
  parameter int bus_size  = 32,
  parameter int addr_size = 5
) (
  input logic              clk,
  input logic              rst,
  register_file_if.slave   bus
);
  localparam int depth = 2 ** addr_size;

  logic [bus_size-1:0] regs [1:depth-1];
  logic [15:0]         count;
  logic                commit;

  // A write only lands for a nonzero destination; r0 has no storage.
  assign commit = bus.wr_en && (bus.rd_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < depth; i++) regs[i] <= '0;
      count <= '0;
    end else if (commit) begin
      regs[bus.rd_addr] <= bus.wr_data;
      count             <= count + 16'd1;
    end
  end

  function automatic logic [bus_size-1:0] stored(input logic [addr_size-1:0] addr);
    if (addr == '0) return '0;
    return regs[addr];
  endfunction

  // Bypass is suppressed during reset so every read port reads zero then.
  function automatic logic [bus_size-1:0] read_port(input logic [addr_size-1:0] addr);
    if (addr == '0) return '0;
    if (!rst && bus.wr_en && (bus.rd_addr == addr)) return bus.wr_data;
    return regs[addr];
  endfunction

  assign bus.rs_data  = read_port(bus.rs_addr);
  assign bus.rt_data  = read_port(bus.rt_addr);
  assign bus.dbg_data = stored(bus.dbg_addr);
  assign bus.wr_count = count;
endmodule
